// File: rtl/parity_pkg.sv
// Shared definitions for the parity-protected word store: widths, writer states
// and the XOR-reduce parity helper used by both the writer and checker paths.
package parity_pkg;

    localparam int DATA_W = 8;
    localparam int WORD_W = DATA_W + 1;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } state_t;

    // Odd number of ones gives 1, matching the checker's compare rule.
    function automatic logic xor_reduce(input logic [DATA_W-1:0] i_d);
        logic r_p;
        r_p = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            r_p = r_p ^ i_d[i];
        end
        return r_p;
    endfunction

endpackage

// File: rtl/parity_gen.sv
// Combinational XOR tree producing the parity bit of one data byte; shared
// between the store writer and the fetch/parity-check path.
module parity_gen #(
    parameter int DATA_W = parity_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] i_data,
    output logic              o_parity
);

    assign o_parity = ^i_data;

endmodule

// File: rtl/parity_word_writer.sv
// Writer side of the parity-protected word store: accepts bytes, appends parity
// and writes {data, parity} words to a two-bank store. Optional ERR_INJECT_EN
// adds err_addr/err_arm to force a parity error at one address.
module parity_word_writer #(
    parameter int DEPTH  = parity_pkg::DEPTH,
    parameter int DATA_W = parity_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
`ifdef ERR_INJECT_EN
    input  logic [$clog2(DEPTH)-1:0]   err_addr,
    input  logic                       err_arm,
`endif
    output logic                       in_ready,
    output logic                       wr_en,
    output logic                       wr_bank,
    output logic [$clog2(DEPTH)-1:0]   wr_addr,
    output logic [DATA_W:0]            wr_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       done
);

    import parity_pkg::*;

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_wr_en;
    logic [AW-1:0]      r_wr_addr;
    logic [DATA_W:0]    r_wr_data;

    logic               w_accept;
    logic               w_last;
    logic               w_parity;
    logic               w_flip;

    parity_gen #(.DATA_W(DATA_W)) u_parity_gen (
        .i_data   (in_data),
        .o_parity (w_parity)
    );

    // start has priority over a byte offered in the same cycle.
    assign w_accept = (r_state == FILL) && in_valid && !start;
    // The low count bits double as the write pointer.
    assign w_last   = (r_count[AW-1:0] == AW'(DEPTH - 1));

`ifdef ERR_INJECT_EN
    assign w_flip = err_arm && (err_addr == r_count[AW-1:0]);
`else
    assign w_flip = 1'b0;
`endif

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = FILL;
            FILL: begin
                if (start) begin
                    w_next_state = FILL;
                end else if (w_accept && w_last) begin
                    w_next_state = FULL;
                end
            end
            FULL:    if (start) w_next_state = FILL;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (start) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count   <= r_count + 1'b1;
                r_wr_addr <= r_count[AW-1:0];
                r_wr_data <= {in_data, w_parity ^ w_flip};
            end
        end
    end

    assign in_ready = (r_state == FILL);
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_bank  = r_wr_addr[AW-1];
    assign wr_data  = r_wr_data;
    assign count    = r_count;
    assign done     = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_parity_word_writer.sv
// Randomised scoreboard bench for parity_word_writer: the driver predicts each
// write from a count/parity model, and a negedge monitor matches DUT writes.
module tb_parity_word_writer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic       wr_bank;
    logic [3:0] wr_addr;
    logic [8:0] wr_data;
    logic [4:0] count;
    logic       done;
`ifdef ERR_INJECT_EN
    logic [3:0] err_addr;
    logic       err_arm;
`endif

    parity_word_writer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
`ifdef ERR_INJECT_EN
        .err_addr (err_addr),
        .err_arm  (err_arm),
`endif
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .count    (count),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [8:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    bit         m_filling;
    int         m_count;
    logic [3:0] last_addr;
    logic [8:0] last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference word: data followed by a bit that is 1 for an odd population count.
    function automatic logic [8:0] ref_word(input logic [7:0] d, input bit corrupt);
        logic p;
        p = (($countones(d) % 2) == 1);
        return {d, p ^ corrupt};
    endfunction

    // One clock of stimulus; the model predicts the effect of the coming edge.
    task automatic step(input bit s, input bit v, input logic [7:0] d);
        exp_t e;
        bit   corrupt;
        start    = s;
        in_valid = v;
        in_data  = d;
        corrupt  = 1'b0;
`ifdef ERR_INJECT_EN
        corrupt = err_arm && (err_addr == 4'(m_count));
`endif
        if (s) begin
            m_filling = 1'b1;
            m_count   = 0;
        end else if (v && m_filling) begin
            e.addr = 4'(m_count);
            e.data = ref_word(d, corrupt);
            exp_q.push_back(e);
            m_count++;
            if (m_count == 16) m_filling = 1'b0;
        end
        @(posedge clk);
        #1;
        check("in_ready", in_ready, m_filling);
        check("count", count, m_count);
        check("done", done, m_count == 16);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: wr_en=1 addr=%0d data=0x%0h, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
                check("wr_bank", wr_bank, e.addr[3]);
                last_addr = e.addr;
                last_data = e.data;
            end
        end else begin
            check("hold_addr", wr_addr, last_addr);
            check("hold_data", wr_data, last_data);
        end
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        m_filling = 1'b0;
        m_count   = 0;
        last_addr = '0;
        last_data = '0;
`ifdef ERR_INJECT_EN
        err_arm  = 1'b0;
        err_addr = 4'd0;
`endif
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_bank", wr_bank, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle ignores bytes; then two directed parity words.
        step(0, 1, 8'hAA);
        step(1, 0, 8'h00);
        step(0, 1, 8'b0001_1111);
        step(0, 1, 8'b0011_0001);

        // Full back-to-back fill of 16 bytes.
        step(1, 0, 8'h00);
        for (int i = 0; i < 16; i++) step(0, 1, 8'(i));
        step(0, 1, 8'hFF);
        step(0, 1, 8'hFF);

        // Restart from FULL with a byte in the start cycle, which is dropped.
        step(1, 1, 8'h77);
        step(0, 1, 8'h88);

        // Abort a partial fill; the byte alongside start is dropped.
        step(1, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom));
        step(1, 1, 8'hAA);
        step(0, 1, 8'h55);

        // Asynchronous reset mid-fill at count 7 while a write is showing.
        step(1, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 1, 8'($urandom));
        reset = 1'b1;
        #1;
        check("midrst_wr_en", wr_en, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_count", count, 0);
        check("midrst_in_ready", in_ready, 0);
        exp_q.delete();
        m_filling = 1'b0;
        m_count   = 0;
        last_addr = '0;
        last_data = '0;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        step(0, 1, 8'h3C);
        step(0, 1, 8'h3D);

`ifdef ERR_INJECT_EN
        // Forced parity error at address 3 only.
        err_arm  = 1'b1;
        err_addr = 4'd3;
        step(1, 0, 8'h00);
        for (int i = 0; i < 16; i++) step(0, 1, 8'(i));
        err_arm = 1'b0;
`endif

        // Random traffic: occasional start, gappy valid, random data.
        for (int n = 0; n < 1500; n++) begin
`ifdef ERR_INJECT_EN
            err_arm  = ($urandom_range(0, 3) == 0);
            err_addr = 4'($urandom);
`endif
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
        end
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_word_writer.md
Name: parity_word_writer

Overview:
- Writer side of the parity-protected word store.
- Accepts 8-bit data bytes over a valid/ready handshake and computes each byte's parity bit.
- Writes the 9-bit word {data, parity} into a 16-entry store split into two 8-entry banks; address bit 3 selects the bank, bits 2:0 select the entry.
- The existing counter-driven fetch/parity-check path later reads the store back and checks every word.

Parameters:
- DEPTH, 16, number of words per fill; power of two, fixed at 16 for the two-bank layout.
- DATA_W, 8, data byte width; word width is DATA_W+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new fill at address 0.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  8  data byte to store.
- in_ready  out  1  writer can accept a byte this cycle.
- wr_en  out  1  write strobe to the store, one cycle per word.
- wr_bank  out  1  bank select (equals wr_addr[3]).
- wr_addr  out  4  word address.
- wr_data  out  9  {data[7:0], parity}; parity at bit 0.
- count  out  5  words written in the current fill, 0..16.
- done  out  1  high while the fill is complete.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; in_ready=0, wr_en=0, wr_bank=0, wr_addr=0, wr_data=0, count=0, done=0.
- Parity: parity = XOR of in_data[7:0], i.e. 1 when the byte has an odd number of ones. This matches the checker, which flags a match when the data XOR equals the stored bit.
- States:
  - IDLE: in_ready=0. On start -> FILL with pointer=0, count=0.
  - FILL: in_ready=1. On in_valid&&in_ready, the byte is accepted.
    - Next cycle: wr_en=1, wr_addr=pointer, wr_bank=pointer[3], wr_data={in_data, parity}.
    - Pointer and count increment. Latency is exactly 1 cycle, and a new byte is accepted every cycle.
    - When the 16th word is accepted (pointer 15) -> FULL.
  - FULL: in_ready=0, done=1. Bytes are ignored with no write. On start -> FILL, clearing done and count in the same edge.
- Outputs are registered. wr_en is high for exactly one cycle per accepted byte and low otherwise. wr_addr/wr_data hold their last values while wr_en=0.
- The 4-bit pointer wraps 15->0 only through start. A write to address 0 after address 15 never happens without start.
- start during FILL aborts the fill: pointer=0, count=0. A byte presented in the same cycle as start is dropped (start has priority).
- start in IDLE/FULL together with in_valid: the byte is not accepted; in_ready rises on the next cycle.
- Reset during FILL discards the partial fill immediately, with no further wr_en. Words already written stay in the store; the writer does not clear it.
- count saturates at 16. done=1 iff count==16.

Optional Feature:
- Macro ERR_INJECT_EN.
- When defined: add input err_addr[3:0] and input err_arm. While err_arm=1, the word written to address err_addr has its parity bit inverted, so the checker reports a mismatch at exactly that counter value. All other words are unaffected.
- When undefined: the ports are absent and parity is always correct.

Decomposition:
- Shared package parity_pkg: DATA_W, WORD_W=DATA_W+1, DEPTH, ADDR_W=4, state enum {IDLE, FILL, FULL}, function for XOR-reduce parity.
- One sub-module, parity_gen: combinational 8-bit XOR tree producing the parity bit. It is reusable by the checker path.

Test Plan:
- Reset then start, bytes 8'b00011111 and 8'b00110001 -> wr_data 9'b000111111 @addr0, 9'b001100011 @addr1, wr_bank=0, one cycle after each acceptance.
- Stream 16 back-to-back bytes 0x00..0x0F -> 16 consecutive wr_en pulses, addr 0..15, wr_bank=1 for addr 8..15, then done=1, count=16, in_ready=0.
- In FULL, present in_valid with 0xFF -> no wr_en; start then byte 0x88 -> 9'b100010000 @addr0, done=0.
- Abort: start, 5 words written, start again with in_valid=1 -> that byte dropped, count=0, next byte lands at addr0.
- Assert reset mid-fill at count=7 -> all outputs 0 immediately (before the next clk edge), no further writes.
- With ERR_INJECT_EN, err_arm=1, err_addr=3, fill 0x00..0x0F -> only the addr3 word (data 0x03) has parity 1 instead of 0.
